// File: rtl/armleocpu_ptw_arbiter.sv
// Arbitrates the single page-table walker between the instruction TLB (r0) and data TLB (r1).
// Define ARMLEOCPU_PTW_ARB_RESULT_REG_EN to register the PTW result for one extra cycle (RESP state).
module armleocpu_ptw_arbiter #(
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        async_rst,

    input  logic        r0_resolve_request,
    output logic        r0_resolve_ack,
    input  logic [19:0] r0_virtual_address,
    output logic        r0_resolve_done,
    output logic        r0_resolve_pagefault,
    output logic        r0_resolve_accessfault,
    output logic [7:0]  r0_resolve_access_bits,
    output logic [21:0] r0_resolve_physical_address,

    input  logic        r1_resolve_request,
    output logic        r1_resolve_ack,
    input  logic [19:0] r1_virtual_address,
    output logic        r1_resolve_done,
    output logic        r1_resolve_pagefault,
    output logic        r1_resolve_accessfault,
    output logic [7:0]  r1_resolve_access_bits,
    output logic [21:0] r1_resolve_physical_address,

    output logic        ptw_resolve_request,
    input  logic        ptw_resolve_ack,
    output logic [19:0] ptw_virtual_address,
    input  logic        ptw_resolve_done,
    input  logic        ptw_resolve_pagefault,
    input  logic        ptw_resolve_accessfault,
    input  logic [7:0]  ptw_resolve_access_bits,
    input  logic [21:0] ptw_resolve_physical_address
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
`ifdef ARMLEOCPU_PTW_ARB_RESULT_REG_EN
        , S_RESP
`endif
    } state_t;

    state_t      state, state_nxt;
    logic        grant, grant_nxt;
    logic        last_grant, last_grant_nxt;
    logic [19:0] vaddr_q, vaddr_nxt;
    logic        win;

    logic        res_valid;
    logic        res_pagefault;
    logic        res_accessfault;
    logic [7:0]  res_access_bits;
    logic [21:0] res_physical_address;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state      <= S_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            vaddr_q    <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            vaddr_q    <= vaddr_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        grant_nxt           = grant;
        last_grant_nxt      = last_grant;
        vaddr_nxt           = vaddr_q;
        r0_resolve_ack      = 1'b0;
        r1_resolve_ack      = 1'b0;
        ptw_resolve_request = 1'b0;

        // Contention: round-robin hands it to whoever did not win last; otherwise data side wins.
        if (r0_resolve_request && r1_resolve_request)
            win = (ROUND_ROBIN != 0) ? ~last_grant : 1'b1;
        else
            win = r1_resolve_request;

        case (state)
            S_IDLE: begin
                if ((r0_resolve_request || r1_resolve_request) && !async_rst) begin
                    r0_resolve_ack = ~win;
                    r1_resolve_ack = win;
                    grant_nxt      = win;
                    vaddr_nxt      = win ? r1_virtual_address : r0_virtual_address;
                    state_nxt      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ptw_resolve_request = 1'b1;
                if (ptw_resolve_ack)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (ptw_resolve_done) begin
                    last_grant_nxt = grant;
`ifdef ARMLEOCPU_PTW_ARB_RESULT_REG_EN
                    state_nxt      = S_RESP;
`else
                    state_nxt      = S_IDLE;
`endif
                end
            end
`ifdef ARMLEOCPU_PTW_ARB_RESULT_REG_EN
            S_RESP: state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef ARMLEOCPU_PTW_ARB_RESULT_REG_EN
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            res_pagefault        <= 1'b0;
            res_accessfault      <= 1'b0;
            res_access_bits      <= '0;
            res_physical_address <= '0;
        end else if (state == S_WAIT && ptw_resolve_done) begin
            res_pagefault        <= ptw_resolve_pagefault;
            res_accessfault      <= ptw_resolve_accessfault;
            res_access_bits      <= ptw_resolve_access_bits;
            res_physical_address <= ptw_resolve_physical_address;
        end
    end

    assign res_valid = (state == S_RESP);
`else
    assign res_valid            = (state == S_WAIT) && ptw_resolve_done;
    assign res_pagefault        = ptw_resolve_pagefault;
    assign res_accessfault      = ptw_resolve_accessfault;
    assign res_access_bits      = ptw_resolve_access_bits;
    assign res_physical_address = ptw_resolve_physical_address;
`endif

    assign ptw_virtual_address = vaddr_q;

    // Fields are masked with done so the non-granted port reads all zeros.
    assign r0_resolve_done             = res_valid & ~grant;
    assign r0_resolve_pagefault        = r0_resolve_done & res_pagefault;
    assign r0_resolve_accessfault      = r0_resolve_done & res_accessfault;
    assign r0_resolve_access_bits      = {8{r0_resolve_done}} & res_access_bits;
    assign r0_resolve_physical_address = {22{r0_resolve_done}} & res_physical_address;

    assign r1_resolve_done             = res_valid & grant;
    assign r1_resolve_pagefault        = r1_resolve_done & res_pagefault;
    assign r1_resolve_accessfault      = r1_resolve_done & res_accessfault;
    assign r1_resolve_access_bits      = {8{r1_resolve_done}} & res_access_bits;
    assign r1_resolve_physical_address = {22{r1_resolve_done}} & res_physical_address;

    // A result strobe outside WAIT is a PTW protocol error.
    assert property (@(posedge clk) disable iff (async_rst) ptw_resolve_done |-> (state == S_WAIT));

endmodule

// File: tb/tb_armleocpu_ptw_arbiter.sv
// Directed plus randomized bench for armleocpu_ptw_arbiter; instance 0 is round-robin, instance 1 fixed priority.
module tb_armleocpu_ptw_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        r0_req [2], r1_req [2], r0_ack [2], r1_ack [2];
    logic [19:0] r0_va [2], r1_va [2], ptw_va [2];
    logic        r0_done [2], r1_done [2], r0_pf [2], r1_pf [2], r0_af [2], r1_af [2];
    logic [7:0]  r0_bits [2], r1_bits [2], ptw_bits [2];
    logic [21:0] r0_ppn [2], r1_ppn [2], ptw_ppn [2];
    logic        ptw_req [2], ptw_ack [2], ptw_done [2], ptw_pf [2], ptw_af [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        armleocpu_ptw_arbiter #(.ROUND_ROBIN((k == 0) ? 1 : 0)) dut (
            .clk                          (clk),
            .async_rst                    (rst[k]),
            .r0_resolve_request           (r0_req[k]),
            .r0_resolve_ack               (r0_ack[k]),
            .r0_virtual_address           (r0_va[k]),
            .r0_resolve_done              (r0_done[k]),
            .r0_resolve_pagefault         (r0_pf[k]),
            .r0_resolve_accessfault       (r0_af[k]),
            .r0_resolve_access_bits       (r0_bits[k]),
            .r0_resolve_physical_address  (r0_ppn[k]),
            .r1_resolve_request           (r1_req[k]),
            .r1_resolve_ack               (r1_ack[k]),
            .r1_virtual_address           (r1_va[k]),
            .r1_resolve_done              (r1_done[k]),
            .r1_resolve_pagefault         (r1_pf[k]),
            .r1_resolve_accessfault       (r1_af[k]),
            .r1_resolve_access_bits       (r1_bits[k]),
            .r1_resolve_physical_address  (r1_ppn[k]),
            .ptw_resolve_request          (ptw_req[k]),
            .ptw_resolve_ack              (ptw_ack[k]),
            .ptw_virtual_address          (ptw_va[k]),
            .ptw_resolve_done             (ptw_done[k]),
            .ptw_resolve_pagefault        (ptw_pf[k]),
            .ptw_resolve_accessfault      (ptw_af[k]),
            .ptw_resolve_access_bits      (ptw_bits[k]),
            .ptw_resolve_physical_address (ptw_ppn[k])
        );
    end

    int vectors = 0;
    int miscompares = 0;
    int last [2];

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_zero(input int k);
        check("r0_ack", k, r0_ack[k], 0);
        check("r1_ack", k, r1_ack[k], 0);
        check("r0_done", k, r0_done[k], 0);
        check("r1_done", k, r1_done[k], 0);
        check("r0_fields", k, {r0_pf[k], r0_af[k], r0_bits[k], r0_ppn[k]}, 0);
        check("r1_fields", k, {r1_pf[k], r1_af[k], r1_bits[k], r1_ppn[k]}, 0);
        check("ptw_req", k, ptw_req[k], 0);
        check("ptw_va", k, ptw_va[k], 0);
    endtask

    task automatic chk_res(input int k, input int p, input logic d, input logic pf, input logic af,
                           input logic [7:0] b, input logic [21:0] n);
        if (p == 0) begin
            check("r0_done", k, r0_done[k], d);
            check("r0_pf", k, r0_pf[k], pf);
            check("r0_af", k, r0_af[k], af);
            check("r0_bits", k, r0_bits[k], b);
            check("r0_ppn", k, r0_ppn[k], n);
        end else begin
            check("r1_done", k, r1_done[k], d);
            check("r1_pf", k, r1_pf[k], pf);
            check("r1_af", k, r1_af[k], af);
            check("r1_bits", k, r1_bits[k], b);
            check("r1_ppn", k, r1_ppn[k], n);
        end
    endtask

    task automatic reset_dut(input int k);
        @(negedge clk);
        rst[k] = 1'b1; r0_req[k] = 1'b1; r1_req[k] = 1'b1;
        #1 chk_zero(k);
        @(posedge clk);
        @(negedge clk);
        r0_req[k] = 1'b0; r1_req[k] = 1'b0; rst[k] = 1'b0;
        last[k] = 1;
    endtask

    task automatic release_reqs(input int k);
        #1 r0_req[k] = 1'b0; r1_req[k] = 1'b0;
    endtask

    // One full walk: requests applied, winner served with a PTW that acks after ackd and completes after doned.
    task automatic walk(input int k, input logic q0, input logic q1, input logic [19:0] a0, input logic [19:0] a1,
                        input int ackd, input int doned, input logic pf, input logic af,
                        input logic [7:0] b, input logic [21:0] n);
        int w;
        logic [19:0] wva;
        @(negedge clk);
        r0_req[k] = q0; r1_req[k] = q1; r0_va[k] = a0; r1_va[k] = a1;
        if (q0 && q1) w = (k == 0) ? 1 - last[k] : 1;
        else w = q1 ? 1 : 0;
        wva = (w == 1) ? a1 : a0;
        #1;
        check("r0_ack", k, r0_ack[k], w == 0);
        check("r1_ack", k, r1_ack[k], w == 1);
        @(posedge clk);
        #1;
        r0_va[k] = 20'($urandom); r1_va[k] = 20'($urandom);
        if (w == 0) r0_req[k] = 1'b0; else r1_req[k] = 1'b0;
        repeat (ackd) begin
            @(negedge clk);
            check("ptw_req_hold", k, ptw_req[k], 1);
            check("ptw_va_hold", k, ptw_va[k], wva);
            check("acks_issue", k, {r0_ack[k], r1_ack[k]}, 0);
            @(posedge clk);
        end
        @(negedge clk);
        ptw_ack[k] = 1'b1;
        #1;
        check("ptw_req", k, ptw_req[k], 1);
        check("ptw_va", k, ptw_va[k], wva);
        @(posedge clk);
        #1 ptw_ack[k] = 1'b0;
        repeat (doned) begin
            @(negedge clk);
            check("ptw_req_wait", k, ptw_req[k], 0);
            check("dones_wait", k, {r0_done[k], r1_done[k]}, 0);
            check("acks_wait", k, {r0_ack[k], r1_ack[k]}, 0);
            @(posedge clk);
        end
        @(negedge clk);
        ptw_done[k] = 1'b1; ptw_pf[k] = pf; ptw_af[k] = af; ptw_bits[k] = b; ptw_ppn[k] = n;
        #1;
`ifdef ARMLEOCPU_PTW_ARB_RESULT_REG_EN
        check("dones_pre_resp", k, {r0_done[k], r1_done[k]}, 0);
        @(posedge clk);
        #1;
        ptw_done[k] = 1'b0; ptw_pf[k] = ~pf; ptw_af[k] = ~af;
        ptw_bits[k] = 8'($urandom); ptw_ppn[k] = 22'($urandom);
        @(negedge clk);
`endif
        chk_res(k, w, 1'b1, pf, af, b, n);
        chk_res(k, 1 - w, 1'b0, 1'b0, 1'b0, 8'h00, 22'h0);
        @(posedge clk);
        #1;
        ptw_done[k] = 1'b0; ptw_pf[k] = 1'b0; ptw_af[k] = 1'b0;
        ptw_bits[k] = 8'($urandom); ptw_ppn[k] = 22'($urandom);
        last[k] = w;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] pat;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; r0_req[k] = 1'b0; r1_req[k] = 1'b0; r0_va[k] = '0; r1_va[k] = '0;
            ptw_ack[k] = 1'b0; ptw_done[k] = 1'b0; ptw_pf[k] = 1'b0; ptw_af[k] = 1'b0;
            ptw_bits[k] = '0; ptw_ppn[k] = '0; last[k] = 1;
        end
        reset_dut(0);
        reset_dut(1);

        // Single r0 walk with the reference values.
        walk(0, 1, 0, 20'h12345, 20'h0, 0, 5, 0, 0, 8'hCF, 22'h0ABCD);
        release_reqs(0);

        // Contention from reset with round-robin: r0, then held r1, then r0 again.
        reset_dut(0);
        walk(0, 1, 1, 20'h11111, 20'h22222, 0, 2, 0, 0, 8'h11, 22'h01111);
        walk(0, 0, 1, 20'h0, 20'h22222, 0, 2, 1, 0, 8'h22, 22'h02222);
        walk(0, 1, 1, 20'h33333, 20'h44444, 1, 1, 0, 0, 8'h33, 22'h03333);
        release_reqs(0);

        // Fixed priority: r1 wins every contended grant.
        for (int i = 0; i < 3; i++)
            walk(1, 1, 1, 20'hAAAAA, 20'(20'h55550 + i), 0, 1, 0, 0, 8'(i), 22'(i + 7));
        release_reqs(1);

        // Access fault routed to r1, PTW ack stalls for three cycles.
        walk(0, 0, 1, 20'h0, 20'hFEDCB, 0, 2, 0, 1, 8'h5A, 22'h3FFFFF);
        walk(0, 1, 0, 20'hBEEF1, 20'h0, 3, 1, 1, 1, 8'hFF, 22'h12345);
        release_reqs(0);

        // Async reset while waiting on the PTW; a result strobe under reset must not surface.
        @(negedge clk);
        r0_req[0] = 1'b1; r0_va[0] = 20'h0F0F0;
        #1 check("rst_walk_ack", 0, r0_ack[0], 1);
        @(posedge clk);
        #1 r0_req[0] = 1'b0;
        @(negedge clk);
        ptw_ack[0] = 1'b1;
        #1 check("rst_walk_ptw_req", 0, ptw_req[0], 1);
        @(posedge clk);
        #1 ptw_ack[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        #1 chk_zero(0);
        @(posedge clk);
        @(negedge clk);
        ptw_done[0] = 1'b1; ptw_bits[0] = 8'hC3; ptw_ppn[0] = 22'h00777;
        #1 chk_zero(0);
        @(posedge clk);
        @(negedge clk);
        ptw_done[0] = 1'b0; rst[0] = 1'b0; last[0] = 1;
        #1 chk_zero(0);
        walk(0, 1, 1, 20'h13579, 20'h2468A, 0, 1, 0, 0, 8'h0F, 22'h0F0F0);
        release_reqs(0);

        // Randomized walks on both arbiters.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 20; i++) begin
                pat = 2'($urandom_range(1, 3));
                walk(k, pat[0], pat[1], 20'($urandom), 20'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                     1'($urandom), 1'($urandom), 8'($urandom), 22'($urandom));
            end
            release_reqs(k);
            @(negedge clk);
            @(negedge clk);
            check("idle_after_release", k, {r0_ack[k], r1_ack[k], ptw_req[k]}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
